// File: rtl/tuss_echo_timer.sv
// Ultrasonic time-of-flight timer for a TUSS transducer driver.
// It drives the burst, blanks the ring-down, then timestamps the first echo edge or times out.
module tuss_echo_timer #(
    parameter int BURST_CYC   = 200,
    parameter int BLANK_CYC   = 5000,
    parameter int TIMEOUT_CYC = 1000000,
    parameter int HOLDOFF_CYC = 100000
) (
    input  logic        gclk,
    input  logic        rst,
    input  logic        tuss_ready,
    input  logic        trigger,
    input  logic        echo_n,
    output logic        burst_en,
    output logic        busy,
    output logic [23:0] tof,
    output logic        tof_valid,
    output logic        timeout
);

    localparam logic [23:0] LP_BURST_LAST   = 24'(BURST_CYC - 1);
    localparam logic [23:0] LP_BLANK_LAST   = 24'(BURST_CYC + BLANK_CYC - 1);
    localparam logic [23:0] LP_TIMEOUT_LAST = 24'(TIMEOUT_CYC - 1);
    localparam logic [23:0] LP_TIMEOUT_VAL  = 24'(TIMEOUT_CYC);
    localparam logic [23:0] LP_HOLD_LAST    = 24'(HOLDOFF_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BURST,
        S_BLANK,
        S_LISTEN,
        S_HOLDOFF
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_sync1;
    logic        r_sync2;
    logic        r_sync2_d;
    logic [23:0] r_elapsed;
    logic [23:0] r_hold_cnt;
    logic        r_burst_en;
    logic        r_busy;
    logic [23:0] r_tof;
    logic        r_tof_valid;
    logic        r_timeout;
    logic        w_echo;
    logic        w_done;
    logic        w_active;
    logic        w_next_active;

    // Idle-high comparator, so the flops reset high to avoid a false edge after reset.
    always_ff @(posedge gclk or posedge rst) begin
        if (rst) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_sync2_d <= 1'b1;
        end else begin
            r_sync1   <= echo_n;
            r_sync2   <= r_sync1;
            r_sync2_d <= r_sync2;
        end
    end

    assign w_echo = r_sync2_d & ~r_sync2;

    always_ff @(posedge gclk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (trigger && tuss_ready) begin
                    w_next = S_BURST;
                end
            end
            S_BURST: begin
                if (!tuss_ready) begin
                    w_next = S_IDLE;
                end else if (r_elapsed == LP_BURST_LAST) begin
                    w_next = S_BLANK;
                end
            end
            S_BLANK: begin
                if (!tuss_ready) begin
                    w_next = S_IDLE;
                end else if (r_elapsed == LP_BLANK_LAST) begin
                    w_next = S_LISTEN;
                end
            end
            S_LISTEN: begin
                // A lost configuration aborts silently, even if an echo arrives in the same cycle.
                if (!tuss_ready) begin
                    w_next = S_IDLE;
                end else if (w_echo || (r_elapsed == LP_TIMEOUT_LAST)) begin
                    w_done = 1'b1;
                    w_next = S_HOLDOFF;
                end
            end
            S_HOLDOFF: begin
                if (r_hold_cnt == LP_HOLD_LAST) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign w_active      = (r_state == S_BURST) || (r_state == S_BLANK) || (r_state == S_LISTEN);
    assign w_next_active = (w_next == S_BURST) || (w_next == S_BLANK) || (w_next == S_LISTEN);

    always_ff @(posedge gclk or posedge rst) begin
        if (rst) begin
            r_elapsed  <= '0;
            r_hold_cnt <= '0;
        end else begin
            r_elapsed  <= (w_active && w_next_active) ? r_elapsed + 24'd1 : '0;
            r_hold_cnt <= ((r_state == S_HOLDOFF) && (w_next == S_HOLDOFF)) ? r_hold_cnt + 24'd1 : '0;
        end
    end

    // Outputs follow the next state, so they line up with the state they describe.
    always_ff @(posedge gclk or posedge rst) begin
        if (rst) begin
            r_burst_en  <= 1'b0;
            r_busy      <= 1'b0;
            r_tof       <= '0;
            r_tof_valid <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_burst_en  <= (w_next == S_BURST);
            r_busy      <= (w_next != S_IDLE);
            r_tof_valid <= w_done;
            if (w_done) begin
                r_tof     <= w_echo ? r_elapsed : LP_TIMEOUT_VAL;
                r_timeout <= ~w_echo;
            end
        end
    end

    assign burst_en  = r_burst_en;
    assign busy      = r_busy;
    assign tof       = r_tof;
    assign tof_valid = r_tof_valid;
    assign timeout   = r_timeout;

endmodule

// File: tb/tb_tuss_echo_timer.sv
// Testbench for tuss_echo_timer: directed vector table, hand sequences, and
// randomized echo patterns checked against a cycle-index reference model.
module tb_tuss_echo_timer;

    localparam int BURST = 4;
    localparam int BLANK = 10;
    localparam int TMO   = 100;
    localparam int HOLD  = 8;

    typedef struct {
        int id;
        int lowStart;
        int lowLen;
        int low2Start;
        int low2Len;
        int abortAt;
        int rstAt;
        int trigInHold;
        int expTof;
        int expTimeout;
    } vec_t;

    logic        gclk;
    logic        rst;
    logic        tuss_ready;
    logic        trigger;
    logic        echo_n;
    logic        burst_en;
    logic        busy;
    logic [23:0] tof;
    logic        tof_valid;
    logic        timeout;

    int testsRun;
    int testsFailed;

    vec_t vecs[10];

    tuss_echo_timer #(
        .BURST_CYC  (BURST),
        .BLANK_CYC  (BLANK),
        .TIMEOUT_CYC(TMO),
        .HOLDOFF_CYC(HOLD)
    ) dut (
        .gclk      (gclk),
        .rst       (rst),
        .tuss_ready(tuss_ready),
        .trigger   (trigger),
        .echo_n    (echo_n),
        .burst_en  (burst_en),
        .busy      (busy),
        .tof       (tof),
        .tof_valid (tof_valid),
        .timeout   (timeout)
    );

    initial gclk = 1'b0;
    always #5 gclk = ~gclk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Is echo_n driven low during the cycle whose elapsed count is e?
    function automatic bit lowAt(input vec_t v, input int e);
        return ((v.lowStart >= 0) && (e >= v.lowStart) && (e < v.lowStart + v.lowLen)) ||
               ((v.low2Start >= 0) && (e >= v.low2Start) && (e < v.low2Start + v.low2Len));
    endfunction

    // Synchronized level at cycle e is the raw level two cycles earlier; the first
    // high-to-low change of that level inside the listen window is the echo.
    function automatic void model(input vec_t v, output int expTof, output int expTimeout);
        expTof     = TMO;
        expTimeout = 1;
        for (int e = BURST + BLANK; e <= TMO - 1; e++) begin
            if (lowAt(v, e - 2) && !lowAt(v, e - 3)) begin
                expTof     = e;
                expTimeout = 0;
                break;
            end
        end
    endfunction

    task automatic applyStimulus(input vec_t v);
        int pulseAt;
        int busyFallAt;
        int burstCnt;
        int pulses;
        int stopAt;
        int gotTof;
        int gotTo;
        int burstFirst;
        int lateBusy;
        string tag;
        tag        = $sformatf("v%0d", v.id);
        pulseAt    = -1;
        busyFallAt = -1;
        burstCnt   = 0;
        pulses     = 0;
        gotTof     = 0;
        gotTo      = 0;
        burstFirst = 0;
        lateBusy   = 0;
        stopAt     = 400;
        if (v.abortAt >= 0) stopAt = v.abortAt + 30;
        if (v.rstAt >= 0) stopAt = v.rstAt + 30;

        @(posedge gclk); #1;
        trigger = 1'b1;
        @(posedge gclk); #1;
        trigger = 1'b0;
        for (int e = 0; e < stopAt; e++) begin
            echo_n  = !lowAt(v, e);
            trigger = (v.trigInHold != 0) && (pulseAt >= 0) && (e == pulseAt + 2);
            if (e == v.abortAt) tuss_ready = 1'b0;
            rst = (e == v.rstAt);
            @(negedge gclk);
            if (e == 0) burstFirst = int'(burst_en);
            if (burst_en) burstCnt++;
            if (tof_valid) begin
                pulses++;
                if (pulseAt < 0) begin
                    pulseAt = e;
                    gotTof  = int'(tof);
                    gotTo   = int'(timeout);
                end
            end
            if (pulseAt >= 0 && busyFallAt < 0 && !busy) busyFallAt = e;
            else if (busyFallAt >= 0 && (busy || burst_en)) lateBusy = 1;
            if (v.abortAt >= 0 && e == v.abortAt + 1) begin
                checkOutput({tag, ".abortBusy"}, int'(busy), 0);
                checkOutput({tag, ".abortBurst"}, int'(burst_en), 0);
            end
            if (v.rstAt >= 0 && e == v.rstAt) begin
                checkOutput({tag, ".rstBurst"}, int'(burst_en), 0);
                checkOutput({tag, ".rstBusy"}, int'(busy), 0);
                checkOutput({tag, ".rstTof"}, int'(tof), 0);
                checkOutput({tag, ".rstValid"}, int'(tof_valid), 0);
                checkOutput({tag, ".rstTimeout"}, int'(timeout), 0);
            end
            if (pulseAt >= 0 && stopAt == 400) stopAt = pulseAt + HOLD + 6;
            @(posedge gclk); #1;
        end
        echo_n     = 1'b1;
        trigger    = 1'b0;
        rst        = 1'b0;
        tuss_ready = 1'b1;

        checkOutput({tag, ".burstFirst"}, burstFirst, 1);
        checkOutput({tag, ".burstCnt"}, burstCnt, BURST);
        if (v.abortAt < 0 && v.rstAt < 0) begin
            checkOutput({tag, ".pulses"}, pulses, 1);
            checkOutput({tag, ".tof"}, gotTof, v.expTof);
            checkOutput({tag, ".timeout"}, gotTo, v.expTimeout);
            checkOutput({tag, ".holdoffLen"}, busyFallAt - pulseAt, HOLD);
            checkOutput({tag, ".staysIdle"}, lateBusy, 0);
        end else begin
            checkOutput({tag, ".noPulse"}, pulses, 0);
            checkOutput({tag, ".keptTof"}, int'(tof), v.expTof);
            checkOutput({tag, ".keptTimeout"}, int'(timeout), v.expTimeout);
            checkOutput({tag, ".idleBusy"}, int'(busy), 0);
        end
    endtask

    initial begin
        int seen;
        vec_t rv;
        testsRun    = 0;
        testsFailed = 0;

        //            id lowS len low2S len2 abort rstAt hold expTof expTo
        vecs[0] = '{0, 38, 20, -1, 0, -1, -1, 0, 40, 0};
        vecs[1] = '{1, -1, 0, -1, 0, -1, -1, 1, 100, 1};
        vecs[2] = '{2, 7, 3, 53, 20, -1, -1, 0, 55, 0};
        vecs[3] = '{3, 10, 40, -1, 0, -1, -1, 0, 100, 1};
        vecs[4] = '{4, 12, 5, -1, 0, -1, -1, 0, 14, 0};
        vecs[5] = '{5, 97, 10, -1, 0, -1, -1, 0, 99, 0};
        vecs[6] = '{6, 98, 10, -1, 0, -1, -1, 0, 100, 1};
        vecs[7] = '{7, -1, 0, -1, 0, 20, -1, 0, 100, 1};
        vecs[8] = '{8, -1, 0, -1, 0, -1, 20, 0, 0, 0};
        vecs[9] = '{9, 38, 20, -1, 0, -1, -1, 0, 40, 0};

        rst        = 1'b1;
        tuss_ready = 1'b0;
        trigger    = 1'b0;
        echo_n     = 1'b1;
        repeat (3) @(posedge gclk);
        @(negedge gclk);
        checkOutput("reset.burst_en", int'(burst_en), 0);
        checkOutput("reset.busy", int'(busy), 0);
        checkOutput("reset.tof", int'(tof), 0);
        checkOutput("reset.tof_valid", int'(tof_valid), 0);
        checkOutput("reset.timeout", int'(timeout), 0);
        @(posedge gclk); #1;
        rst = 1'b0;

        // A trigger without tuss_ready must be dropped entirely.
        @(posedge gclk); #1;
        trigger = 1'b1;
        @(posedge gclk); #1;
        trigger = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge gclk);
            if (burst_en || busy || tof_valid) seen = 1;
        end
        checkOutput("notReady.dropped", seen, 0);
        @(posedge gclk); #1;
        tuss_ready = 1'b1;
        repeat (2) @(posedge gclk);
        #1;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i]);
        end

        for (int i = 0; i < 25; i++) begin
            rv.id         = 100 + i;
            rv.lowStart   = int'($urandom_range(0, 110));
            rv.lowLen     = int'($urandom_range(1, 25));
            rv.low2Start  = -1;
            rv.low2Len    = 0;
            if ($urandom_range(0, 1) == 1) begin
                rv.low2Start = rv.lowStart + rv.lowLen + int'($urandom_range(1, 20));
                rv.low2Len   = int'($urandom_range(1, 25));
            end
            rv.abortAt    = -1;
            rv.rstAt      = -1;
            rv.trigInHold = int'($urandom_range(0, 1));
            model(rv, rv.expTof, rv.expTimeout);
            applyStimulus(rv);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
